display_buffer: RTL and testbench

- Parametrised character buffer that feeds the display scan logic: holds DEPTH cells of DATA_W-bit character codes and serves a 1-cycle-latency read port to the scanner.
- Writes arrive as commands over a valid/ready handshake:
  - append at cursor, with left-scroll when full
  - direct write
  - backspace
  - clear
- Optionally overlays a blinking caret at the cursor position on read data.

---
 rtl/display_buffer.sv | 158 +++++++++++++++
 tb/tb_display_buffer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_buffer.sv
// Character buffer feeding the display scanner: handshaked write commands, 1-cycle read port.
// Optional blinking caret overlay on read data, enabled by defining DISPLAY_BUFFER_CARET_BLINK_EN.
//
// state | meaning
// IDLE  | accepting commands, caret overlay may apply to reads
// CLEAR | blanking one cell per cycle, commands stalled
module display_buffer #(
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       DEPTH     = 16,
    parameter logic [DATA_W-1:0] BLANK_CHR = 8'h20,
    parameter logic [DATA_W-1:0] CARET_CHR = 8'h5F,
    parameter int unsigned       BLINK_DIV = 6000000,
    localparam int unsigned      AW        = $clog2(DEPTH),
    localparam int unsigned      CW        = $clog2(DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [1:0]        i_cmd,
    input  logic [AW-1:0]     i_cmd_addr,
    input  logic [DATA_W-1:0] i_cmd_data,
    input  logic              i_rd_en,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    output logic [CW-1:0]     o_cursor,
    output logic              o_full,
    output logic              o_caret_phase
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [1:0]    CMD_APPEND = 2'd0;
    localparam logic [1:0]    CMD_WRITE  = 2'd1;
    localparam logic [1:0]    CMD_BKSP   = 2'd2;
    localparam logic [1:0]    CMD_CLEAR  = 2'd3;
    localparam logic [CW-1:0] CUR_FULL   = CW'(DEPTH);
    localparam logic [AW:0]   DEPTH_X    = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] IDX_LAST   = AW'(DEPTH - 1);

    if (DEPTH < 2 || BLINK_DIV < 1) begin : g_bad_cfg
        $error("display_buffer: DEPTH must be >= 2 and BLINK_DIV >= 1");
    end

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     clr_idx;
    logic [CW-1:0]     cursor;
    logic [CW-1:0]     cursor_m1;
    logic              cmd_fire;
    logic              cur_full;
    logic              wr_in_range;
    logic              rd_in_range;
    logic              caret_phase;
    logic              caret_here;
    logic [DATA_W-1:0] rd_raw;

    assign cmd_fire    = i_cmd_valid && o_cmd_ready;
    assign cur_full    = (cursor == CUR_FULL);
    assign cursor_m1   = cursor - 1'b1;
    assign wr_in_range = ({1'b0, i_cmd_addr} < DEPTH_X);
    assign rd_in_range = ({1'b0, i_rd_addr} < DEPTH_X);
    assign rd_raw      = rd_in_range ? mem[i_rd_addr] : BLANK_CHR;

`ifdef DISPLAY_BUFFER_CARET_BLINK_EN
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    logic [BW-1:0] blink_cnt;

    // Down-counter reloads on terminal count; the phase flips every BLINK_DIV cycles.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            blink_cnt   <= BW'(BLINK_DIV - 1);
            caret_phase <= 1'b0;
        end else if (blink_cnt == '0) begin
            blink_cnt   <= BW'(BLINK_DIV - 1);
            caret_phase <= ~caret_phase;
        end else begin
            blink_cnt <= blink_cnt - 1'b1;
        end
    end

    assign caret_here = caret_phase && (state == IDLE) && !cur_full
                        && (i_rd_addr == cursor[AW-1:0]);
`else
    assign caret_phase = 1'b0;
    assign caret_here  = 1'b0;
`endif

    assign o_caret_phase = caret_phase;
    assign o_cursor      = cursor;
    assign o_full        = cur_full;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= CLEAR;
            clr_idx     <= '0;
            cursor      <= '0;
            o_cmd_ready <= 1'b0;
            o_rd_data   <= BLANK_CHR;
            o_rd_valid  <= 1'b0;
        end else begin
            // Read uses pre-edge memory, so a same-cycle write is not visible yet.
            o_rd_valid <= i_rd_en;
            if (i_rd_en) begin
                o_rd_data <= caret_here ? CARET_CHR : rd_raw;
            end

            case (state)
                CLEAR: begin
                    mem[clr_idx] <= BLANK_CHR;
                    clr_idx      <= clr_idx + 1'b1;
                    if (clr_idx == IDX_LAST) begin
                        cursor      <= '0;
                        state       <= IDLE;
                        o_cmd_ready <= 1'b1;
                    end
                end
                IDLE: begin
                    if (cmd_fire) begin
                        case (i_cmd)
                            CMD_APPEND: begin
                                if (!cur_full) begin
                                    mem[cursor[AW-1:0]] <= i_cmd_data;
                                    cursor              <= cursor + 1'b1;
                                end else begin
                                    for (int k = 0; k < int'(DEPTH) - 1; k++) begin
                                        mem[k] <= mem[k + 1];
                                    end
                                    mem[DEPTH - 1] <= i_cmd_data;
                                end
                            end
                            CMD_WRITE: begin
                                if (wr_in_range) begin
                                    mem[i_cmd_addr] <= i_cmd_data;
                                end
                            end
                            CMD_BKSP: begin
                                if (cursor != '0) begin
                                    cursor                 <= cursor_m1;
                                    mem[cursor_m1[AW-1:0]] <= BLANK_CHR;
                                end
                            end
                            CMD_CLEAR: begin
                                state       <= CLEAR;
                                clr_idx     <= '0;
                                o_cmd_ready <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_display_buffer.sv
// Self-checking bench for display_buffer: directed sequences, a vector table and random
// traffic, all compared against a queue-based reference model of the buffer.
module tb_display_buffer;

    localparam int   DEPTH = 16;
    localparam int   BLINK = 4;
    localparam logic [7:0] BLANK = 8'h20;
    localparam logic [7:0] CARET = 8'h5F;
`ifdef DISPLAY_BUFFER_CARET_BLINK_EN
    localparam bit CARET_ON = 1'b1;
`else
    localparam bit CARET_ON = 1'b0;
`endif

    logic       i_clk, i_reset, i_cmd_valid, o_cmd_ready, i_rd_en, o_rd_valid, o_full, o_caret_phase;
    logic [1:0] i_cmd;
    logic [3:0] i_cmd_addr, i_rd_addr;
    logic [7:0] i_cmd_data, o_rd_data;
    logic [4:0] o_cursor;

    display_buffer #(
        .DATA_W(8), .DEPTH(DEPTH), .BLANK_CHR(BLANK), .CARET_CHR(CARET), .BLINK_DIV(BLINK)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd(i_cmd), .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data), .i_rd_en(i_rd_en),
        .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
        .o_cursor(o_cursor), .o_full(o_full), .o_caret_phase(o_caret_phase)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: cell text as a queue, clear progress as remaining cycles,
    // caret phase from elapsed cycles since reset.
    logic [7:0] m_cells [$];
    int         m_cursor, m_busy, m_cyc;
    logic       m_rd_valid;
    logic [7:0] m_rd_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_phase();
        return CARET_ON ? ((m_cyc / BLINK) % 2) : 0;
    endfunction

    task automatic model_step();
        bit caret;
        if (i_reset) begin
            m_busy = DEPTH; m_cursor = 0; m_rd_data = BLANK; m_rd_valid = 1'b0; m_cyc = 0;
        end else begin
            caret = (m_phase() == 1) && (m_busy == 0) && (m_cursor < DEPTH)
                    && (int'(i_rd_addr) == m_cursor);
            m_rd_valid = i_rd_en;
            if (i_rd_en) m_rd_data = caret ? CARET : m_cells[i_rd_addr];
            if (m_busy > 0) begin
                m_cells[DEPTH - m_busy] = BLANK;
                m_busy--;
                if (m_busy == 0) m_cursor = 0;
            end else if (i_cmd_valid) begin
                case (i_cmd)
                    2'd0: if (m_cursor < DEPTH) begin
                              m_cells[m_cursor] = i_cmd_data;
                              m_cursor++;
                          end else begin
                              m_cells.delete(0);
                              m_cells.push_back(i_cmd_data);
                          end
                    2'd1: m_cells[i_cmd_addr] = i_cmd_data;
                    2'd2: if (m_cursor > 0) begin
                              m_cursor--;
                              m_cells[m_cursor] = BLANK;
                          end
                    default: m_busy = DEPTH;
                endcase
            end
            m_cyc++;
        end
    endtask

    task automatic cycle();
        @(posedge i_clk);
        model_step();
        #1;
        chk("ready", o_cmd_ready, m_busy == 0);
        chk("cursor", o_cursor, m_cursor);
        chk("full", o_full, m_cursor == DEPTH);
        chk("caret_phase", o_caret_phase, m_phase());
        chk("rd_valid", o_rd_valid, m_rd_valid);
        chk("rd_data", o_rd_data, m_rd_data);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!o_cmd_ready && n < 64) begin
            cycle();
            n++;
        end
        if (!o_cmd_ready) chk("ready_timeout", o_cmd_ready, 1);
    endtask

    task automatic do_cmd(input logic [1:0] cmd, input logic [3:0] addr, input logic [7:0] data);
        wait_ready();
        chk("cmd_ready", o_cmd_ready, 1);
        i_cmd_valid = 1'b1; i_cmd = cmd; i_cmd_addr = addr; i_cmd_data = data;
        cycle();
        i_cmd_valid = 1'b0;
    endtask

    task automatic read_cell(input logic [3:0] addr, input logic [7:0] exp);
        i_rd_en = 1'b1; i_rd_addr = addr;
        cycle();
        i_rd_en = 1'b0;
        chk($sformatf("read[%0d]", addr), o_rd_data, exp);
    endtask

    typedef struct {
        logic       v;
        logic [1:0] cmd;
        logic [3:0] addr;
        logic [7:0] data;
        logic       rd;
        logic [3:0] ra;
        logic [4:0] e_cur;
        logic       e_rdv;
        logic [7:0] e_rd;
    } vec_t;
    vec_t tbl [8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_caret, saw_cell, saw_phase1;
        for (int i = 0; i < DEPTH; i++) m_cells.push_back(BLANK);
        m_cursor = 0; m_busy = DEPTH; m_cyc = 0; m_rd_valid = 0; m_rd_data = BLANK;
        i_reset = 1; i_cmd_valid = 0; i_cmd = 0; i_cmd_addr = 0; i_cmd_data = 0;
        i_rd_en = 0; i_rd_addr = 0;

        // 1: reset, 16-cycle clear, all cells blank
        cycle();
        cycle();
        i_reset = 0;
        for (int i = 1; i <= DEPTH; i++) begin
            cycle();
            chk("t1_ready_after_reset", o_cmd_ready, i == DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) read_cell(4'(i), BLANK);
        chk("t1_cursor", o_cursor, 0);

        // 2: fill and scroll
        for (int i = 0; i < DEPTH; i++) do_cmd(2'd0, 4'd0, 8'h41 + 8'(i));
        chk("t2_full", o_full, 1);
        chk("t2_cursor", o_cursor, 16);
        read_cell(4'd0, 8'h41);
        read_cell(4'd15, 8'h50);
        do_cmd(2'd0, 4'd0, 8'h51);
        read_cell(4'd0, 8'h42);
        read_cell(4'd15, 8'h51);
        chk("t2_cursor_scroll", o_cursor, 16);

        // 3: backspace down to empty
        do_cmd(2'd3, 4'd0, 8'h00);
        do_cmd(2'd0, 4'd0, 8'h41);
        do_cmd(2'd0, 4'd0, 8'h42);
        do_cmd(2'd0, 4'd0, 8'h43);
        chk("t3_cursor3", o_cursor, 3);
        do_cmd(2'd2, 4'd0, 8'h00);
        chk("t3_cursor2", o_cursor, 2);
        read_cell(4'd0, 8'h41);
        read_cell(4'd1, 8'h42);
        for (int i = 0; i < 3; i++) do_cmd(2'd2, 4'd0, 8'h00);
        chk("t3_cursor0", o_cursor, 0);
        read_cell(4'd1, BLANK);
        read_cell(4'd2, BLANK);

        // 4: direct write with same-cycle read of the same cell
        wait_ready();
        i_cmd_valid = 1; i_cmd = 2'd1; i_cmd_addr = 4'd5; i_cmd_data = 8'h7A;
        i_rd_en = 1; i_rd_addr = 4'd5;
        cycle();
        i_cmd_valid = 0; i_rd_en = 0;
        chk("t4_read_old", o_rd_data, BLANK);
        read_cell(4'd5, 8'h7A);
        chk("t4_cursor", o_cursor, 0);

        // 5: reset in the middle of a clear restarts it
        do_cmd(2'd0, 4'd0, 8'h61);
        do_cmd(2'd0, 4'd0, 8'h62);
        do_cmd(2'd3, 4'd0, 8'h00);
        for (int i = 0; i < 6; i++) cycle();
        chk("t5_cursor_held", o_cursor, 2);
        i_reset = 1;
        cycle();
        i_reset = 0;
        for (int i = 1; i <= DEPTH; i++) begin
            cycle();
            chk("t5_ready_after_reset", o_cmd_ready, i == DEPTH);
        end
        for (int i = 1; i < DEPTH; i++) read_cell(4'(i), BLANK);
        chk("t5_cursor", o_cursor, 0);

        // vector table, starting from an empty cleared buffer
        tbl[0] = '{1'b1, 2'd0, 4'd0, 8'h31, 1'b1, 4'd7, 5'd1, 1'b1, 8'h20};
        tbl[1] = '{1'b1, 2'd0, 4'd0, 8'h32, 1'b1, 4'd0, 5'd2, 1'b1, 8'h31};
        tbl[2] = '{1'b1, 2'd1, 4'd9, 8'h39, 1'b1, 4'd9, 5'd2, 1'b1, 8'h20};
        tbl[3] = '{1'b0, 2'd0, 4'd0, 8'h00, 1'b1, 4'd9, 5'd2, 1'b1, 8'h39};
        tbl[4] = '{1'b1, 2'd2, 4'd0, 8'h00, 1'b1, 4'd1, 5'd1, 1'b1, 8'h32};
        tbl[5] = '{1'b0, 2'd0, 4'd0, 8'h00, 1'b0, 4'd1, 5'd1, 1'b0, 8'h32};
        tbl[6] = '{1'b1, 2'd0, 4'd0, 8'h33, 1'b1, 4'd0, 5'd2, 1'b1, 8'h31};
        tbl[7] = '{1'b0, 2'd0, 4'd0, 8'h77, 1'b1, 4'd1, 5'd2, 1'b1, 8'h33};
        wait_ready();
        for (int i = 0; i < 8; i++) begin
            i_cmd_valid = tbl[i].v; i_cmd = tbl[i].cmd; i_cmd_addr = tbl[i].addr;
            i_cmd_data = tbl[i].data; i_rd_en = tbl[i].rd; i_rd_addr = tbl[i].ra;
            cycle();
            chk($sformatf("vec%0d_cursor", i), o_cursor, tbl[i].e_cur);
            chk($sformatf("vec%0d_rd_valid", i), o_rd_valid, tbl[i].e_rdv);
            chk($sformatf("vec%0d_rd_data", i), o_rd_data, tbl[i].e_rd);
        end
        i_cmd_valid = 0; i_rd_en = 0;

        // 6: caret blinking over cell 2
        do_cmd(2'd3, 4'd0, 8'h00);
        do_cmd(2'd1, 4'd2, 8'h5A);
        do_cmd(2'd0, 4'd0, 8'h41);
        do_cmd(2'd0, 4'd0, 8'h42);
        saw_caret = 0; saw_cell = 0; saw_phase1 = 0;
        i_rd_en = 1; i_rd_addr = 4'd2;
        for (int i = 0; i < 24; i++) begin
            cycle();
            if (o_rd_data == CARET) saw_caret = 1;
            if (o_rd_data == 8'h5A) saw_cell = 1;
            if (o_caret_phase) saw_phase1 = 1;
        end
        i_rd_en = 0;
        chk("t6_caret_seen", saw_caret, CARET_ON);
        chk("t6_cell_seen", saw_cell, 1);
        chk("t6_phase_seen", saw_phase1, CARET_ON);

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            i_reset     = ($urandom_range(199) == 0);
            i_cmd_valid = ($urandom_range(9) < 7);
            i_cmd       = ($urandom_range(15) == 0) ? 2'd3 : 2'($urandom_range(2));
            i_cmd_addr  = 4'($urandom);
            i_cmd_data  = 8'($urandom);
            i_rd_en     = 1'($urandom_range(1));
            i_rd_addr   = 4'($urandom);
            cycle();
        end
        i_reset = 0; i_cmd_valid = 0; i_rd_en = 0;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
